// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/accumulate unit: op codes,
// FSM states and the default iteration count of the shift-add multiplier.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIX,
    S_ACC
  } state_e;

  localparam int MUL_ITERS = 32;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step,
// product accumulated in the upper half and shifted right each step.
module hilo_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum;

  assign last    = (cnt_q == LAST_CNT);
  assign product = prod_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (load) begin
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      end
      // carry-out of the add becomes the new product MSB
      prod_d   = {sum, prod_q[WIDTH-1:1]};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      if (!last) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO owner: MULT/MULTU/MADD/MSUB via the sequential multiplier with a
// sign-fix pass, plus direct MTHI/MTLO writes. Raises Stall while busy.
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = MUL_ITERS
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] fix_q, fix_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               mult_load;
  logic               mult_step;
  logic               mult_last;
  logic [2*WIDTH-1:0] mult_prod;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;
  logic [2*WIDTH-1:0] acc;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
    return v[WIDTH-1] ? (-v) : v;
  endfunction

  assign mcand_in  = is_signed_op(Op) ? mag(A) : A;
  assign mplier_in = is_signed_op(Op) ? mag(B) : B;

  hilo_seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load      (mult_load),
    .step      (mult_step),
    .mcand_in  (mcand_in),
    .mplier_in (mplier_in),
    .last      (mult_last),
    .product   (mult_prod)
  );

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Done  = done_q;
  assign Busy  = (state_q != S_IDLE);
  assign Stall = Busy & (Start | HiLoRead);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    fix_d     = fix_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    mult_load = 1'b0;
    mult_step = 1'b0;
    acc       = {hi_q, lo_q};
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              op_d      = Op;
              neg_d     = is_signed_op(Op) && (A[WIDTH-1] ^ B[WIDTH-1]);
              mult_load = 1'b1;
              state_d   = S_MUL;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        mult_step = 1'b1;
        if (mult_last) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        fix_d   = neg_q ? (-mult_prod) : mult_prod;
        state_d = S_ACC;
      end
      S_ACC: begin
        case (op_q)
          OP_MADD: acc = {hi_q, lo_q} + fix_q;
          OP_MSUB: acc = {hi_q, lo_q} - fix_q;
          default: acc = fix_q;
        endcase
        hi_d    = acc[2*WIDTH-1:WIDTH];
        lo_d    = acc[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // operation context is only meaningful while busy, so it needs no reset
  always_ff @(posedge Clk) begin
    op_q  <= op_d;
    neg_q <= neg_d;
    fix_q <= fix_d;
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed cases plus random ops
// checked against a 64-bit arithmetic model of {HI,LO}.
module tb_hilo_mult_unit;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, MADD = 3'd2,
                         MSUB = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        HiLoRead = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy, Done, Stall;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] m_hilo  = '0;

  hilo_mult_unit #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .HiLoRead (HiLoRead),
    .HI       (HI),
    .LO       (LO),
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall)
  );

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op == MULTU) return {32'b0, a} * {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // MTHI / MTLO: result and Done visible in the cycle after the accepting edge
  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (op == MTHI) m_hilo[63:32] = a; else m_hilo[31:0] = a;
    @(negedge Clk);
    chk("mt_done", {63'b0, Done}, 64'd1);
    chk("mt_busy", {63'b0, Busy}, 64'd0);
    chk("mt_hilo", {HI, LO}, m_hilo);
  endtask

  // mode 0: plain; 1: inject Start/MTHI while busy; 2: hold HiLoRead high
  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode);
    logic [63:0] p;
    int busy_cnt;
    bit got_done;
    busy_cnt = 0;
    got_done = 0;
    p = ref_prod(op, a, b);
    case (op)
      MADD:    m_hilo = m_hilo + p;
      MSUB:    m_hilo = m_hilo - p;
      default: m_hilo = p;
    endcase
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    if (mode == 2) HiLoRead = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        got_done = 1;
        break;
      end
      busy_cnt += int'(Busy);
      if (mode == 1 && i == 5) begin
        Start = 1'b1; Op = MTHI; A = 32'hDEADBEEF;
        #1 chk("stall_start", {63'b0, Stall}, 64'd1);
      end
      if (mode == 2 && i == 10) chk("stall_read", {63'b0, Stall}, 64'd1);
    end
    chk("done_seen", {63'b0, got_done}, 64'd1);
    chk("busy_cycles", 64'(busy_cnt), 64'd34);
    chk("done_busy", {63'b0, Busy}, 64'd0);
    chk("result", {HI, LO}, m_hilo);
    if (mode == 2) begin
      chk("stall_drop", {63'b0, Stall}, 64'd0);
      HiLoRead = 1'b0;
    end
    @(negedge Clk);
    chk("done_pulse", {63'b0, Done}, 64'd0);
  endtask

  initial begin
    logic [31:0] corner [4];
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    corner[0] = 32'h80000000; corner[1] = 32'hFFFFFFFF;
    corner[2] = 32'h7FFFFFFF; corner[3] = 32'h00000000;

    // reset state
    #12;
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_ctl", {61'b0, Busy, Done, Stall}, 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_mul(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_max", {HI, LO}, 64'hFFFFFFFE_00000001);
    run_mul(MULT, 32'hFFFFFFFD, 32'd7, 0);
    chk("mult_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
    run_mul(MULT, 32'h80000000, 32'h80000000, 0);
    chk("mult_min", {HI, LO}, 64'h40000000_00000000);

    run_mt(MTHI, 32'h12345678);
    run_mt(MTLO, 32'h9);
    run_mul(MADD, 32'd2, 32'd3, 0);
    chk("madd_seq", {HI, LO}, 64'h12345678_0000000F);

    run_mt(MTHI, 32'h0);
    run_mt(MTLO, 32'h5);
    run_mul(MSUB, 32'h10, 32'd1, 0);
    chk("msub_seq", {HI, LO}, 64'hFFFFFFFF_FFFFFFF5);

    // issue during busy, then HiLoRead during busy
    run_mul(MULT, 32'hFFFFFF00, 32'h00001234, 1);
    run_mul(MADD, 32'h00000FFF, 32'hFFFFFFF0, 2);

    // undefined op is ignored
    @(negedge Clk);
    Start = 1'b1; Op = 3'd6; A = 32'hA5A5A5A5;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    chk("undef_ctl", {62'b0, Busy, Done}, 64'd0);
    chk("undef_hilo", {HI, LO}, m_hilo);

    // reset in the middle of a MULTU
    @(negedge Clk);
    Start = 1'b1; Op = MULTU; A = 32'hFFFF0000; B = 32'h0000FFFF;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst_hilo", {HI, LO}, 64'd0);
    chk("midrst_ctl", {62'b0, Busy, Done}, 64'd0);
    m_hilo = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_mul(MULTU, 32'd6, 32'd7, 0);
    chk("post_rst", {32'b0, LO}, 64'd42);

    // random mix against the arithmetic model
    for (int k = 0; k < 16; k++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      if (rop == MTHI || rop == MTLO) run_mt(rop, ra);
      else run_mul(rop, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
